vending_change: RTL
===================

VENDING_CHANGE -- requirements
Module: vending_change

Interface
REQ-001 SHALL have parameter PRICE, default 15: product price in rupees; a multiple of 5, minimum 5.
REQ-002 SHALL have parameter CW, default 8: credit register width; PRICE+20 < 2**CW is required.
REQ-003 SHALL have input clk, 1 bit: single clock, rising-edge active.
REQ-004 SHALL have input rst, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have input coin, 2 bits: coin value this cycle.
- 00 = none, 01 = 5, 10 = 10, 11 = 20.
REQ-006 SHALL have input cancel, 1 bit: request refund of all held credit.
REQ-007 SHALL have output out, 1 bit: dispense product, one-cycle pulse.
REQ-008 SHALL have output change, 1 bit: return one 5-rupee coin per high cycle.
REQ-009 SHALL have output credit, CW bits: current held credit in rupees.
REQ-010 SHALL have output busy, 1 bit: high while vending or returning change; coins are not accepted.
REQ-011 SHALL have output coin_rej, 1 bit: registered one-cycle pulse for a coin presented while busy.

Function
REQ-012 SHALL implement a state machine with three states: ACCEPT, VEND, CHANGE.
REQ-013 SHALL derive out = (state==VEND), change = (state==CHANGE) and busy = (state!=ACCEPT); all three are Moore outputs.
REQ-014 In ACCEPT, a nonzero coin SHALL update credit to credit+value at that edge.
REQ-015 In ACCEPT with cancel=0, if the new credit is >= PRICE, the next state SHALL be VEND; otherwise it SHALL remain ACCEPT.
REQ-016 In VEND, the block SHALL set credit to credit-PRICE at the next edge.
- Next state is CHANGE if the result is > 0, else ACCEPT.
- out is therefore high for exactly one cycle per vend.
REQ-017 In CHANGE, the block SHALL decrement credit by 5 at each edge.
- The state SHALL return to ACCEPT at the edge where credit reaches 0.
- Number of change cycles = remaining credit / 5.
REQ-018 In ACCEPT, cancel=1 with (credit + coin value) > 0 SHALL:
- load credit + coin value;
- enter CHANGE (full refund, no vend), even if the sum is >= PRICE.
REQ-019 cancel=1 in ACCEPT with zero credit and no coin SHALL have no effect.
REQ-020 cancel in VEND or CHANGE SHALL be ignored.
REQ-021 A nonzero coin in VEND or CHANGE SHALL NOT change credit, and SHALL assert coin_rej in the following cycle.
REQ-022 Latency: a qualifying coin sampled at edge t SHALL produce out high in the cycle between edges t and t+1.
REQ-023 Credit arithmetic SHALL be unsigned CW-bit and never wraps, given REQ-002 (maximum credit is PRICE-5+20).
REQ-024 An undefined state encoding SHALL recover to ACCEPT with credit unchanged.

Reset
REQ-025 While rst=0, the block SHALL force state=ACCEPT, credit=0, out=0, change=0, busy=0, coin_rej=0, independent of clk.
REQ-026 Reset asserted mid-VEND or mid-CHANGE SHALL abort the operation immediately and discard the remaining credit; no further out or change pulses are issued.
REQ-027 After rst deasserts, the first coin SHALL be accepted at the first rising edge.

Verification
REQ-028 PRICE=15: coin 01 then 10 on consecutive cycles -> credit 5, 15; out pulses once; zero change pulses; credit returns to 0.
REQ-029 PRICE=15: coin 10, 10 -> credit 10, 20; out pulse; then one change pulse; credit 5 -> 0; busy high for 2 cycles.
REQ-030 PRICE=15: coin 11 at idle -> credit 20; out pulse, then one change pulse; back to ACCEPT in 2 cycles.
REQ-031 PRICE=15: coin 01, coin 01, then cancel -> credit 10; two change pulses; out never asserted.
REQ-032 PRICE=15: coin 01 while in CHANGE -> coin_rej pulse next cycle, credit unaffected; coin 10 with cancel=1 at credit 5 -> refund 15 via three change pulses, no out.
REQ-033 PRICE=25, CW=8: coin 10, 10, 10 -> out after the third coin; one change pulse. Separately, rst low during CHANGE -> credit 0, change low immediately.

Source files
------------

// File: rtl/vending_change.sv
// Coin-operated vending controller with 5-rupee change return.
// Accepts 5/10/20 rupee coins, dispenses once credit covers PRICE, then
// pays out any excess one 5-rupee coin per cycle. Cancel refunds all credit.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_ACCEPT | idle/collecting coins; credit accumulates
//   ST_VEND   | out pulses for this one cycle; PRICE is deducted on exit
//   ST_CHANGE | change pulses each cycle; 5 is deducted per cycle
module vending_change #(
   parameter int unsigned PRICE = 15,
   parameter int unsigned CW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    coin,
   input  logic          cancel,
   output logic          out,
   output logic          change,
   output logic [CW-1:0] credit,
   output logic          busy,
   output logic          coin_rej
);

   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_VEND   = 2'd1,
      ST_CHANGE = 2'd2
   } state_e;

   localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
   localparam logic [CW-1:0] FIVE_C  = CW'(5);

   state_e        state_q, state_d;
   logic [CW-1:0] credit_q, credit_d;
   logic          coin_rej_q, coin_rej_d;
   logic [CW-1:0] coin_val;
   logic [CW-1:0] sum;

   // Decode the coin code into rupees.
   always_comb begin
      coin_val = '0;
      case (coin)
         2'b01:   coin_val = CW'(5);
         2'b10:   coin_val = CW'(10);
         2'b11:   coin_val = CW'(20);
         default: coin_val = '0;
      endcase
   end

   // Width is sized so that the largest reachable sum cannot wrap.
   assign sum = credit_q + coin_val;

   // Next-state and credit update.
   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      coin_rej_d = 1'b0;
      case (state_q)
         ST_ACCEPT: begin
            if (cancel) begin
               // Cancel refunds everything, including a coin arriving now,
               // even if that coin would have covered the price.
               if (sum != '0) begin
                  credit_d = sum;
                  state_d  = ST_CHANGE;
               end
            end else begin
               credit_d = sum;
               if (sum >= PRICE_C) state_d = ST_VEND;
            end
         end
         ST_VEND: begin
            coin_rej_d = (coin != 2'b00);
            if (credit_q > PRICE_C) begin
               credit_d = credit_q - PRICE_C;
               state_d  = ST_CHANGE;
            end else begin
               credit_d = '0;
               state_d  = ST_ACCEPT;
            end
         end
         ST_CHANGE: begin
            coin_rej_d = (coin != 2'b00);
            // Credit is always a multiple of 5; the <= guard keeps a
            // corrupted value from underflowing.
            if (credit_q <= FIVE_C) begin
               credit_d = '0;
               state_d  = ST_ACCEPT;
            end else begin
               credit_d = credit_q - FIVE_C;
            end
         end
         default: begin
            // Illegal encoding: return to idle, keep the customer's credit.
            coin_rej_d = (coin != 2'b00);
            state_d    = ST_ACCEPT;
         end
      endcase
   end

   // State, credit and reject-pulse registers; reset drops all credit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_ACCEPT;
         credit_q   <= '0;
         coin_rej_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         coin_rej_q <= coin_rej_d;
      end
   end

   // Moore outputs straight from registered state.
   always_comb begin
      out      = (state_q == ST_VEND);
      change   = (state_q == ST_CHANGE);
      busy     = (state_q != ST_ACCEPT);
      credit   = credit_q;
      coin_rej = coin_rej_q;
   end

endmodule
